// File: rtl/pdp11_instr_encoder_pkg.sv
// Shared types, base opcodes and helpers for the PDP-11 symbolic instruction encoder.
package pdp11_instr_encoder_pkg;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  mode_t;
    typedef logic [2:0]  reg_t;
    typedef logic [7:0]  ofst_t;

    typedef enum logic [5:0] {
        OP_MOV, OP_CMP, OP_BIT, OP_BIC, OP_BIS, OP_ADD, OP_SUB,
        OP_MOVB, OP_CMPB, OP_BITB, OP_BICB, OP_BISB,
        OP_CLR, OP_COM, OP_INC, OP_DEC, OP_NEG, OP_ADC,
        OP_SBC, OP_TST, OP_ROR, OP_ROL, OP_ASR, OP_ASL,
        OP_CLRB, OP_COMB, OP_INCB, OP_DECB, OP_NEGB, OP_ADCB,
        OP_SBCB, OP_TSTB, OP_RORB, OP_ROLB, OP_ASRB, OP_ASLB,
        OP_JMP, OP_SWAB, OP_JSR, OP_RTS,
        OP_BR, OP_BNE, OP_BEQ, OP_BGE, OP_BLT, OP_BGT, OP_BLE,
        OP_BPL, OP_BMI, OP_BHI, OP_BLOS, OP_BVC, OP_BVS, OP_BCC, OP_BCS,
        OP_HALT, OP_NOP
    } opcode_mnemonic;

    typedef enum logic [1:0] {IDLE, INSTR, SEXT, DEXT} enc_state_t;

    typedef enum logic [2:0] {
        CLS_DOP, CLS_SOP, CLS_BR, CLS_JSR, CLS_RTS, CLS_JMPSWAB, CLS_SYS
    } op_class_t;

    // Byte variants share the word-form base with bit 15 set.
    localparam word_t BYTE_BIT  = 16'o100000;

    localparam word_t BASE_MOV  = 16'o010000;
    localparam word_t BASE_CMP  = 16'o020000;
    localparam word_t BASE_BIT  = 16'o030000;
    localparam word_t BASE_BIC  = 16'o040000;
    localparam word_t BASE_BIS  = 16'o050000;
    localparam word_t BASE_ADD  = 16'o060000;
    localparam word_t BASE_SUB  = 16'o160000;
    localparam word_t BASE_CLR  = 16'o005000;
    localparam word_t BASE_COM  = 16'o005100;
    localparam word_t BASE_INC  = 16'o005200;
    localparam word_t BASE_DEC  = 16'o005300;
    localparam word_t BASE_NEG  = 16'o005400;
    localparam word_t BASE_ADC  = 16'o005500;
    localparam word_t BASE_SBC  = 16'o005600;
    localparam word_t BASE_TST  = 16'o005700;
    localparam word_t BASE_ROR  = 16'o006000;
    localparam word_t BASE_ROL  = 16'o006100;
    localparam word_t BASE_ASR  = 16'o006200;
    localparam word_t BASE_ASL  = 16'o006300;
    localparam word_t BASE_JMP  = 16'o000100;
    localparam word_t BASE_SWAB = 16'o000300;
    localparam word_t BASE_JSR  = 16'o004000;
    localparam word_t BASE_RTS  = 16'o000200;
    localparam word_t BASE_BR   = 16'o000400;
    localparam word_t BASE_BNE  = 16'o001000;
    localparam word_t BASE_BEQ  = 16'o001400;
    localparam word_t BASE_BGE  = 16'o002000;
    localparam word_t BASE_BLT  = 16'o002400;
    localparam word_t BASE_BGT  = 16'o003000;
    localparam word_t BASE_BLE  = 16'o003400;
    localparam word_t BASE_BPL  = 16'o100000;
    localparam word_t BASE_BMI  = 16'o100400;
    localparam word_t BASE_BHI  = 16'o101000;
    localparam word_t BASE_BLOS = 16'o101400;
    localparam word_t BASE_BVC  = 16'o102000;
    localparam word_t BASE_BVS  = 16'o102400;
    localparam word_t BASE_BCC  = 16'o103000;
    localparam word_t BASE_BCS  = 16'o103400;
    localparam word_t BASE_HALT = 16'o000000;
    localparam word_t BASE_NOP  = 16'o000240;

    // Index/deferred-index always carry a word; autoincrement through PC is immediate/absolute.
    function automatic logic needs_ext(input mode_t mode, input reg_t rn);
        logic ext_s;
        ext_s = (mode == 3'd6) || (mode == 3'd7) ||
                (((mode == 3'd2) || (mode == 3'd3)) && (rn == 3'd7));
        return ext_s;
    endfunction

endpackage

// File: rtl/pdp11_instr_encoder_base_rom.sv
// Combinational lookup from mnemonic to base opcode word and operand-packing class.
module pdp11_enc_base_rom
    import pdp11_instr_encoder_pkg::*;
(
    input  opcode_mnemonic op_i,
    output word_t          base_o,
    output op_class_t      cls_o
);

    word_t base_s;
    logic  byte_s;

    // Word-form base opcode per mnemonic; byte forms map onto their word sibling.
    always_comb begin
        base_s = BASE_HALT;
        case (op_i)
            OP_MOV,  OP_MOVB: base_s = BASE_MOV;
            OP_CMP,  OP_CMPB: base_s = BASE_CMP;
            OP_BIT,  OP_BITB: base_s = BASE_BIT;
            OP_BIC,  OP_BICB: base_s = BASE_BIC;
            OP_BIS,  OP_BISB: base_s = BASE_BIS;
            OP_ADD:           base_s = BASE_ADD;
            OP_SUB:           base_s = BASE_SUB;
            OP_CLR,  OP_CLRB: base_s = BASE_CLR;
            OP_COM,  OP_COMB: base_s = BASE_COM;
            OP_INC,  OP_INCB: base_s = BASE_INC;
            OP_DEC,  OP_DECB: base_s = BASE_DEC;
            OP_NEG,  OP_NEGB: base_s = BASE_NEG;
            OP_ADC,  OP_ADCB: base_s = BASE_ADC;
            OP_SBC,  OP_SBCB: base_s = BASE_SBC;
            OP_TST,  OP_TSTB: base_s = BASE_TST;
            OP_ROR,  OP_RORB: base_s = BASE_ROR;
            OP_ROL,  OP_ROLB: base_s = BASE_ROL;
            OP_ASR,  OP_ASRB: base_s = BASE_ASR;
            OP_ASL,  OP_ASLB: base_s = BASE_ASL;
            OP_JMP:           base_s = BASE_JMP;
            OP_SWAB:          base_s = BASE_SWAB;
            OP_JSR:           base_s = BASE_JSR;
            OP_RTS:           base_s = BASE_RTS;
            OP_BR:            base_s = BASE_BR;
            OP_BNE:           base_s = BASE_BNE;
            OP_BEQ:           base_s = BASE_BEQ;
            OP_BGE:           base_s = BASE_BGE;
            OP_BLT:           base_s = BASE_BLT;
            OP_BGT:           base_s = BASE_BGT;
            OP_BLE:           base_s = BASE_BLE;
            OP_BPL:           base_s = BASE_BPL;
            OP_BMI:           base_s = BASE_BMI;
            OP_BHI:           base_s = BASE_BHI;
            OP_BLOS:          base_s = BASE_BLOS;
            OP_BVC:           base_s = BASE_BVC;
            OP_BVS:           base_s = BASE_BVS;
            OP_BCC:           base_s = BASE_BCC;
            OP_BCS:           base_s = BASE_BCS;
            OP_NOP:           base_s = BASE_NOP;
            default:          base_s = BASE_HALT;
        endcase
    end

    // Operand class and byte flag per mnemonic.
    always_comb begin
        cls_o  = CLS_SYS;
        byte_s = 1'b0;
        case (op_i)
            OP_MOV, OP_CMP, OP_BIT, OP_BIC, OP_BIS, OP_ADD, OP_SUB:
                cls_o = CLS_DOP;
            OP_MOVB, OP_CMPB, OP_BITB, OP_BICB, OP_BISB: begin
                cls_o  = CLS_DOP;
                byte_s = 1'b1;
            end
            OP_CLR, OP_COM, OP_INC, OP_DEC, OP_NEG, OP_ADC,
            OP_SBC, OP_TST, OP_ROR, OP_ROL, OP_ASR, OP_ASL:
                cls_o = CLS_SOP;
            OP_CLRB, OP_COMB, OP_INCB, OP_DECB, OP_NEGB, OP_ADCB,
            OP_SBCB, OP_TSTB, OP_RORB, OP_ROLB, OP_ASRB, OP_ASLB: begin
                cls_o  = CLS_SOP;
                byte_s = 1'b1;
            end
            OP_JMP, OP_SWAB: cls_o = CLS_JMPSWAB;
            OP_JSR:          cls_o = CLS_JSR;
            OP_RTS:          cls_o = CLS_RTS;
            OP_BR, OP_BNE, OP_BEQ, OP_BGE, OP_BLT, OP_BGT, OP_BLE,
            OP_BPL, OP_BMI, OP_BHI, OP_BLOS, OP_BVC, OP_BVS, OP_BCC, OP_BCS:
                cls_o = CLS_BR;
            default: cls_o = CLS_SYS;
        endcase
    end

    assign base_o = byte_s ? (base_s | BYTE_BIT) : base_s;

endmodule

// File: rtl/pdp11_instr_encoder.sv
// Streams one symbolic PDP-11 instruction as its instruction word followed by
// optional source and destination extension words over a valid/ready port.
module pdp11_instr_encoder
    import pdp11_instr_encoder_pkg::*;
#(
    parameter bit ERR_ON_JMP_REG = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  opcode_mnemonic req_op,
    input  logic [2:0]     req_smod,
    input  logic [2:0]     req_sreg,
    input  logic [2:0]     req_dmod,
    input  logic [2:0]     req_dreg,
    input  logic [7:0]     req_ofst,
    input  logic [15:0]    req_sext,
    input  logic [15:0]    req_dext,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [15:0]    out_word,
    output logic           out_first,
    output logic           out_last,
    output logic           err
);

    enc_state_t state_q, state_d;
    word_t      out_word_q, out_word_d, sext_q, sext_d, dext_q, dext_d;
    logic       out_valid_q, out_valid_d, out_first_q, out_first_d;
    logic       out_last_q, out_last_d, req_ready_q, req_ready_d, err_q, err_d;
    logic       need_sext_q, need_sext_d, need_dext_q, need_dext_d;

    word_t      base_s, instr_word_s;
    op_class_t  cls_s;
    logic       need_sext_s, need_dext_s, reject_s, xfer_s;

    pdp11_enc_base_rom u_rom (
        .op_i   (req_op),
        .base_o (base_s),
        .cls_o  (cls_s)
    );

    // Pack operand fields into the base word according to the instruction class.
    always_comb begin
        instr_word_s = base_s;
        case (cls_s)
            CLS_DOP:          instr_word_s = base_s | {4'b0, req_smod, req_sreg, req_dmod, req_dreg};
            CLS_SOP,
            CLS_JMPSWAB:      instr_word_s = base_s | {10'b0, req_dmod, req_dreg};
            CLS_JSR:          instr_word_s = base_s | {7'b0, req_sreg, req_dmod, req_dreg};
            CLS_RTS:          instr_word_s = base_s | {13'b0, req_sreg};
            CLS_BR:           instr_word_s = base_s | {8'b0, req_ofst};
            default:          instr_word_s = base_s;
        endcase
    end

    assign need_sext_s = (cls_s == CLS_DOP) && needs_ext(req_smod, req_sreg);
    assign need_dext_s = ((cls_s == CLS_DOP) || (cls_s == CLS_SOP) ||
                          (cls_s == CLS_JMPSWAB) || (cls_s == CLS_JSR)) &&
                         needs_ext(req_dmod, req_dreg);
    assign reject_s    = ERR_ON_JMP_REG && ((req_op == OP_JMP) || (req_op == OP_JSR)) &&
                         (req_dmod == 3'd0);
    assign xfer_s      = out_valid_q && out_ready;

    // Next-state and next-output computation for the word sequencer.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        req_ready_d = req_ready_q;
        err_d       = 1'b0;
        sext_d      = sext_q;
        dext_d      = dext_q;
        need_sext_d = need_sext_q;
        need_dext_d = need_dext_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (reject_s) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = INSTR;
                        out_valid_d = 1'b1;
                        out_word_d  = instr_word_s;
                        out_first_d = 1'b1;
                        out_last_d  = !need_sext_s && !need_dext_s;
                        sext_d      = req_sext;
                        dext_d      = req_dext;
                        need_sext_d = need_sext_s;
                        need_dext_d = need_dext_s;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            INSTR, SEXT, DEXT: begin
                if (!xfer_s) begin
                    out_valid_d = 1'b1;
                end else if ((state_q == INSTR) && need_sext_q) begin
                    state_d     = SEXT;
                    out_word_d  = sext_q;
                    out_first_d = 1'b0;
                    out_last_d  = !need_dext_q;
                end else if ((state_q != DEXT) && need_dext_q) begin
                    state_d     = DEXT;
                    out_word_d  = dext_q;
                    out_first_d = 1'b0;
                    out_last_d  = 1'b1;
                end else begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_word_d  = 16'o0;
                    out_first_d = 1'b0;
                    out_last_d  = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset discards any in-flight words.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_word_q  <= 16'o0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            req_ready_q <= 1'b1;
            err_q       <= 1'b0;
            sext_q      <= 16'o0;
            dext_q      <= 16'o0;
            need_sext_q <= 1'b0;
            need_dext_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            req_ready_q <= req_ready_d;
            err_q       <= err_d;
            sext_q      <= sext_d;
            dext_q      <= dext_d;
            need_sext_q <= need_sext_d;
            need_dext_q <= need_dext_d;
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pdp11_instr_encoder.sv
// Scoreboard bench for pdp11_instr_encoder: expected words queued at request time, checked on transfer.
module tb_pdp11_instr_encoder;
    import pdp11_instr_encoder_pkg::*;

    typedef struct packed {
        logic [15:0] w;
        logic        f;
        logic        l;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           req_valid = 1'b0, req_valid2 = 1'b0, out_ready = 1'b1;
    opcode_mnemonic req_op = OP_HALT;
    logic [2:0]     req_smod = 3'd0, req_sreg = 3'd0, req_dmod = 3'd0, req_dreg = 3'd0;
    logic [7:0]     req_ofst = 8'd0;
    logic [15:0]    req_sext = 16'd0, req_dext = 16'd0;
    logic           req_ready, out_valid, out_first, out_last, err;
    logic [15:0]    out_word;
    logic           req_ready2, out2_valid, out2_first, out2_last, err2;
    logic [15:0]    out2_word;

    exp_t sb_q[$];
    int   total = 0, bad = 0, err_seen = 0, cyc = 0;
    int   a0, a1;

    pdp11_instr_encoder dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_smod(req_smod), .req_sreg(req_sreg), .req_dmod(req_dmod),
        .req_dreg(req_dreg), .req_ofst(req_ofst), .req_sext(req_sext), .req_dext(req_dext),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_first(out_first), .out_last(out_last), .err(err)
    );

    pdp11_instr_encoder #(.ERR_ON_JMP_REG(1'b0)) dut_nj (
        .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_op(req_op), .req_smod(req_smod), .req_sreg(req_sreg), .req_dmod(req_dmod),
        .req_dreg(req_dreg), .req_ofst(req_ofst), .req_sext(req_sext), .req_dext(req_dext),
        .out_valid(out2_valid), .out_ready(1'b1), .out_word(out2_word),
        .out_first(out2_first), .out_last(out2_last), .err(err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
        end
    endtask

    // Transfer monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (err === 1'b1) err_seen++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("extra_word", {16'd0, out_word}, 32'hffff_ffff);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("word", {16'd0, out_word}, {16'd0, e.w});
                chk("first", {31'd0, out_first}, {31'd0, e.f});
                chk("last", {31'd0, out_last}, {31'd0, e.l});
            end
        end
    end

    // Issue one request (called at posedge+1); n expected words, n=0 means a reject is expected.
    task automatic send(input opcode_mnemonic op, input int sm, input int sr, input int dm,
                        input int dr, input int of, input int se, input int de, input int n,
                        input int w0, input int w1, input int w2, output int acc);
        int   ws[3];
        int   b;
        exp_t e;
        ws = '{w0, w1, w2};
        for (int i = 0; i < n; i++) begin
            e.w = ws[i][15:0];
            e.f = (i == 0);
            e.l = (i == n - 1);
            sb_q.push_back(e);
        end
        req_op = op; req_smod = sm[2:0]; req_sreg = sr[2:0]; req_dmod = dm[2:0];
        req_dreg = dr[2:0]; req_ofst = of[7:0]; req_sext = se[15:0]; req_dext = de[15:0];
        req_valid = 1'b1;
        b = 0;
        while (req_ready !== 1'b1 && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        if (b >= 100) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((sb_q.size() != 0 || req_ready !== 1'b1) && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        if (b >= 200) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_word", {16'd0, out_word}, 32'd0);
        chk("rst_first", {31'd0, out_first}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // MOV R1,R2: single word
        send(OP_MOV, 0, 1, 0, 2, 0, 0, 0, 1, 'o010102, 0, 0, a0);
        chk("movrr_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        chk("movrr_ready", {31'd0, req_ready}, 32'd1);
        chk("movrr_done", {31'd0, out_valid}, 32'd0);

        // MOV #5,@#1000 followed by JSR PC,@#2000: accept spacing is N+1
        send(OP_MOV, 2, 7, 3, 7, 0, 'o5, 'o1000, 3, 'o012737, 'o000005, 'o001000, a0);
        send(OP_JSR, 0, 7, 3, 7, 0, 0, 'o2000, 2, 'o004737, 'o002000, 0, a1);
        chk("mov3_b2b", a1 - a0, 32'd4);
        wait_idle();

        // BNE then CLRB 6(R3) back-to-back
        send(OP_BNE, 5, 5, 5, 5, 'o375, 0, 0, 1, 'o001375, 0, 0, a0);
        send(OP_CLRB, 0, 0, 6, 3, 0, 0, 'o6, 2, 'o105063, 'o000006, 0, a1);
        chk("bne_b2b", a1 - a0, 32'd2);
        wait_idle();

        // JMP R4 rejected by default instance
        send(OP_JMP, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, a0);
        chk("rej_err", {31'd0, err}, 32'd1);
        chk("rej_ready", {31'd0, req_ready}, 32'd0);
        chk("rej_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("rej_err_drop", {31'd0, err}, 32'd0);
        chk("rej_ready_back", {31'd0, req_ready}, 32'd1);
        chk("rej_valid2", {31'd0, out_valid}, 32'd0);

        // Same JMP R4 on the permissive instance
        req_op = OP_JMP; req_dmod = 3'd0; req_dreg = 3'd4; req_valid2 = 1'b1;
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        chk("nj_valid", {31'd0, out2_valid}, 32'd1);
        chk("nj_word", {16'd0, out2_word}, 32'o000104);
        chk("nj_fl", {30'd0, out2_first, out2_last}, 32'd3);
        chk("nj_err", {31'd0, err2}, 32'd0);
        @(posedge clk); #1;
        chk("nj_idle", {30'd0, out2_valid, req_ready2}, 32'd1);

        // Assorted single- and two-word encodings, including ignored fields
        send(OP_RTS, 3, 7, 3, 3, 'hff, 0, 0, 1, 'o000207, 0, 0, a0);
        send(OP_SWAB, 7, 7, 0, 0, 0, 0, 0, 1, 'o000300, 0, 0, a0);
        send(OP_HALT, 7, 7, 7, 7, 'hff, 'hffff, 'hffff, 1, 'o000000, 0, 0, a0);
        send(OP_NOP, 5, 5, 6, 6, 'h12, 0, 0, 1, 'o000240, 0, 0, a0);
        send(OP_ASLB, 0, 0, 2, 2, 0, 0, 0, 1, 'o106322, 0, 0, a0);
        send(OP_SUB, 0, 1, 4, 2, 0, 0, 0, 1, 'o160142, 0, 0, a0);
        send(OP_BCS, 0, 0, 0, 0, 'o003, 0, 0, 1, 'o103403, 0, 0, a0);
        send(OP_MOV, 2, 2, 0, 3, 0, 'o77, 'o77, 1, 'o012203, 0, 0, a0);
        send(OP_ADD, 0, 0, 6, 5, 0, 'o11, 'o4, 2, 'o060065, 'o000004, 0, a0);
        wait_idle();

        // ADD 2(R1),R0 with consumer stalled for three cycles
        out_ready = 1'b0;
        send(OP_ADD, 6, 1, 0, 0, 0, 'o2, 0, 2, 'o066100, 'o000002, 0, a0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_word", {16'd0, out_word}, 32'o066100);
            chk("stall_fl", {30'd0, out_first, out_last}, 32'd2);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle();

        // Reset after the first word of the 3-word MOV
        send(OP_MOV, 2, 7, 3, 7, 0, 'o5, 'o1000, 3, 'o012737, 'o000005, 'o001000, a0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_ready", {31'd0, req_ready}, 32'd1);
        chk("mrst_word", {16'd0, out_word}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mrst_stale", {31'd0, out_valid}, 32'd0);
        end
        send(OP_MOV, 0, 1, 0, 2, 0, 0, 0, 1, 'o010102, 0, 0, a0);
        wait_idle();

        chk("sb_empty", sb_q.size(), 32'd0);
        chk("err_count", err_seen, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
